// File: rtl/btb_fetch_unit_pkg.sv
// btb_fetch_unit_pkg: shared types and sizing helpers for the BTB fetch unit
package btb_fetch_unit_pkg;
  typedef enum logic [1:0] {UPD_NONE, UPD_INC, UPD_DEC, UPD_ALLOC} upd_op_e;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int ctr_weak_t(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction
endpackage

// File: rtl/btb_fetch_unit_btb_table.sv
// btb_table: direct-mapped BTB storage with combinational lookup and train/allocate
module btb_table
  import btb_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_taken,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(ctr_weak_t(CTR_W));
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;
  logic [ENTRIES-1:0] valid;
  entry_t             mem [ENTRIES];
  logic [IDX_W-1:0]   rd_idx, upd_idx;
  logic [TAG_W-1:0]   rd_tag, upd_tag;
  entry_t             upd_e, upd_next;
  upd_op_e            op;
  assign rd_idx    = rd_pc[IDX_W-1:0];
  assign rd_tag    = rd_pc[ADDR_W-1:IDX_W];
  assign upd_idx   = upd_pc[IDX_W-1:0];
  assign upd_tag   = upd_pc[ADDR_W-1:IDX_W];
  assign upd_e     = mem[upd_idx];
  assign rd_taken  = valid[rd_idx] && mem[rd_idx].tag == rd_tag && mem[rd_idx].ctr[CTR_W-1];
  assign rd_target = mem[rd_idx].target;
  always_comb begin
    op = !upd_valid ? UPD_NONE
       : (valid[upd_idx] && upd_e.tag == upd_tag) ? (upd_taken ? UPD_INC : UPD_DEC)
       : (upd_taken ? UPD_ALLOC : UPD_NONE);
    upd_next = upd_e;
    if (op == UPD_INC) begin
      upd_next.target = upd_target;
      upd_next.ctr    = &upd_e.ctr ? upd_e.ctr : upd_e.ctr + CTR_W'(1);
    end else if (op == UPD_DEC) begin
      upd_next.ctr    = |upd_e.ctr ? upd_e.ctr - CTR_W'(1) : upd_e.ctr;
    end else if (op == UPD_ALLOC) begin
      upd_next = '{tag: upd_tag, target: upd_target, ctr: CTR_WEAK_T};
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (op == UPD_ALLOC) valid[upd_idx] <= 1'b1;
  // payload is unobservable while its valid bit is clear, so it carries no reset
  always_ff @(posedge clk)
    if (op != UPD_NONE) mem[upd_idx] <= upd_next;
endmodule

// File: rtl/btb_fetch_unit.sv
// btb_fetch_unit: PC register with BTB-predicted next PC and decode redirect
module btb_fetch_unit
  import btb_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W      = 30,
  parameter int              BTB_ENTRIES = 16,
  parameter int              CTR_W       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              StallF,
  input  logic              i_Redirect,
  input  logic [ADDR_W-1:0] i_RedirectPC,
  input  logic              i_UpdValid,
  input  logic [ADDR_W-1:0] i_UpdPC,
  input  logic              i_UpdTaken,
  input  logic [ADDR_W-1:0] i_UpdTarget,
  output logic [ADDR_W-1:0] o_PC,
  output logic [ADDR_W-1:0] o_PC4,
  output logic              o_PredTaken,
  output logic [ADDR_W-1:0] o_PredTarget
);
  logic [ADDR_W-1:0] hit_target, pc_next;
  btb_table #(.ADDR_W(ADDR_W), .ENTRIES(BTB_ENTRIES), .CTR_W(CTR_W)) u_table (
    .clk        (Clk),
    .rst_n      (Reset),
    .rd_pc      (o_PC),
    .rd_taken   (o_PredTaken),
    .rd_target  (hit_target),
    .upd_valid  (i_UpdValid),
    .upd_pc     (i_UpdPC),
    .upd_taken  (i_UpdTaken),
    .upd_target (i_UpdTarget)
  );
  assign o_PC4        = o_PC + ADDR_W'(1);
  assign o_PredTarget = o_PredTaken ? hit_target : o_PC4;
  assign pc_next      = i_Redirect ? i_RedirectPC : StallF ? o_PC : o_PredTarget;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) o_PC <= RESET_PC;
    else o_PC <= pc_next;
endmodule
